spi_adc_capture: RTL and testbench

Front end of the acoustics capture chain. It periodically reads one hydrophone sample from an external 10-bit SPI ADC, acting as SPI mode-0 master. It presents each sample as `sample_data` plus a timed `data_ready` strobe, which feed the ring buffer's `Input_Data`/`Input_Data_Ready` and the FFT trigger's `data_ready`. It owns sample-rate timing for the whole pipeline.

---
 rtl/acoustics_pkg.sv | 7 +
 rtl/spi_adc_capture_timer.sv | 16 +
 rtl/spi_adc_capture.sv | 93 +++++++++
 tb/tb_spi_adc_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/acoustics_pkg.sv
// acoustics_pkg: shared sample width, capture FSM states and default sample timing
package acoustics_pkg;
  localparam int ADC_BITS = 10;
  localparam int DEF_SAMPLE_PERIOD = 196;
  localparam int DEF_READY_CYCLES = 14;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} adc_state_t;
endpackage

// File: rtl/spi_adc_capture_timer.sv
// sample_rate_timer: enable-gated period counter issuing one conversion-start tick per period
module sample_rate_timer import acoustics_pkg::*; #(
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic clk,
  input  logic reset_b,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  logic [CW-1:0] count;
  assign tick = enable && count == '0;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) count <= '0;
    else count <= (!enable || count == CW'(SAMPLE_PERIOD - 1)) ? '0 : count + 1'b1;
endmodule

// File: rtl/spi_adc_capture.sv
// spi_adc_capture: periodic SPI mode-0 master reading one sample per period from a serial ADC
module spi_adc_capture import acoustics_pkg::*; #(
  parameter int CLK_DIV = 5,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS = 3,
  parameter int DATA_BITS = ADC_BITS,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int READY_CYCLES = DEF_READY_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 enable,
  input  logic                 adc_miso,
  output logic                 adc_sclk,
  output logic                 adc_cs_n,
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 data_ready,
  output logic                 overrun
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int RW = $clog2(READY_CYCLES + 1);
  adc_state_t state;
  logic tick, miso_q, hi, last_div, in_window;
  logic [DW-1:0] div;
  logic [BW-1:0] bit_idx;
  logic [RW-1:0] ready_cnt;
  logic [DATA_BITS-1:0] shreg;
  sample_rate_timer #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_timer (
    .clk(clk),
    .reset_b(reset_b),
    .enable(enable),
    .tick(tick)
  );
  assign last_div = div == DW'(CLK_DIV - 1);
  assign in_window = bit_idx >= BW'(LEAD_BITS) && bit_idx < BW'(LEAD_BITS + DATA_BITS);
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) miso_q <= 1'b0;
    else miso_q <= adc_miso;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      div <= '0;
      hi <= 1'b0;
      bit_idx <= '0;
      shreg <= '0;
      ready_cnt <= '0;
      adc_sclk <= 1'b0;
      adc_cs_n <= 1'b1;
      sample_data <= '0;
      data_ready <= 1'b0;
      overrun <= 1'b0;
    end else begin
      div <= last_div ? '0 : div + 1'b1;
      if (tick && state != IDLE) overrun <= 1'b1;
      if (data_ready) begin
        ready_cnt <= ready_cnt + 1'b1;
        if (ready_cnt == RW'(READY_CYCLES - 1)) data_ready <= 1'b0;
      end
      case (state)
        IDLE: begin
          div <= '0;
          if (tick) begin
            state <= SETUP;
            adc_cs_n <= 1'b0;
          end
        end
        SETUP: if (last_div) begin
          state <= SHIFT;
          hi <= 1'b0;
          bit_idx <= '0;
        end
        SHIFT: if (last_div) begin
          hi <= !hi;
          adc_sclk <= !hi;
          if (hi) begin
            if (in_window) shreg <= {shreg[DATA_BITS-2:0], miso_q};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BW'(FRAME_BITS - 1)) state <= HOLD;
          end
        end
        HOLD: if (last_div) begin
          state <= DONE;
          adc_cs_n <= 1'b1;
          sample_data <= shreg;
          data_ready <= 1'b1;
          ready_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_adc_capture.sv
// tb_spi_adc_capture: scoreboard bench driving a behavioural SPI ADC and checking samples and frame timing
module tb_spi_adc_capture;
  localparam int CLK_DIV = 5, FRAME_BITS = 16, LEAD_BITS = 3, DATA_BITS = 10;
  localparam int SAMPLE_PERIOD = 196, READY_CYCLES = 14, OVR_PERIOD = 100;
  localparam int LATENCY = 1 + CLK_DIV + FRAME_BITS * 2 * CLK_DIV + CLK_DIV;
  localparam int N_RANDOM = 200;
  logic clk = 0, reset_b = 0, enable = 0, o_enable = 0, adc_miso = 0, sel = 0;
  logic adc_sclk, adc_cs_n, data_ready, overrun, o_sclk, o_cs_n, o_ready, o_overrun;
  logic [DATA_BITS-1:0] sample_data, o_data;
  int passed = 0, total = 0, cyc = 0, got = 0, cs_falls = 0, last_rise = -1, t_start = -1;
  logic [DATA_BITS-1:0] stim_q[$], exp_q[$];

  spi_adc_capture dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .adc_miso(adc_miso),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .sample_data(sample_data),
    .data_ready(data_ready), .overrun(overrun)
  );
  spi_adc_capture #(.SAMPLE_PERIOD(OVR_PERIOD)) dut_ovr (
    .clk(clk), .reset_b(reset_b), .enable(o_enable), .adc_miso(adc_miso),
    .adc_sclk(o_sclk), .adc_cs_n(o_cs_n), .sample_data(o_data),
    .data_ready(o_ready), .overrun(o_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame_start(input string name);
    int start = cs_falls;
    for (int i = 0; i < 4 * SAMPLE_PERIOD && cs_falls == start; i++) @(negedge clk);
    if (cs_falls == start) begin
      total++;
      $display("FAIL %s: no frame start within %0d cycles", name, 4 * SAMPLE_PERIOD);
    end
  endtask

  task automatic wait_samples(input string name, input int n, input int budget);
    int target = got + n;
    for (int i = 0; i < budget && got < target; i++) @(negedge clk);
    if (got < target) begin
      total++;
      $display("FAIL %s: got %0d samples, expected %0d within %0d cycles", name, got, target, budget);
    end
  endtask

  // ADC model: MSB-first frame of random lead bits, sample, random trailing bits; advances after SCLK falls
  initial begin
    logic cs, sk, cs_p = 1, sk_p = 0, pend = 0;
    logic [FRAME_BITS-1:0] word = '0;
    logic [DATA_BITS-1:0] v;
    int idx = 0;
    forever begin
      @(negedge clk);
      cs = sel ? o_cs_n : adc_cs_n;
      sk = sel ? o_sclk : adc_sclk;
      if (pend) begin
        idx++;
        if (idx < FRAME_BITS) adc_miso = word[FRAME_BITS-1-idx];
        else adc_miso = 1'($urandom);
      end
      pend = sk_p && !sk;
      if (cs_p && !cs) begin
        if (stim_q.size() > 0) v = stim_q.pop_front();
        else v = DATA_BITS'($urandom);
        exp_q.push_back(v);
        word = {3'($urandom), v, 3'($urandom)};
        idx = 0;
        adc_miso = word[FRAME_BITS-1];
      end
      cs_p = cs;
      sk_p = sk;
    end
  end

  // monitor: scoreboard pop on each data_ready rise plus SCLK/CS/ready timing
  initial begin
    logic r, r_p = 0, cs, cs_p = 1, sk, sk_p = 0;
    int pulses = 0, hi_w = 0, ready_w = 0, sk_rise = -1;
    forever begin
      @(negedge clk);
      r = sel ? o_ready : data_ready;
      cs = sel ? o_cs_n : adc_cs_n;
      sk = sel ? o_sclk : adc_sclk;
      if (cs_p && !cs) begin
        pulses = 0;
        sk_rise = -1;
        cs_falls++;
      end
      if (sk && !sk_p) begin
        pulses++;
        if (sk_rise >= 0) check("sclk_period", cyc - sk_rise, 2 * CLK_DIV);
        sk_rise = cyc;
        hi_w = 0;
      end
      if (sk) hi_w++;
      if (!sk && sk_p && reset_b) check("sclk_high", hi_w, CLK_DIV);
      if (r && !r_p) begin
        got++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_ready: data_ready rose with data %0h, no sample expected", sel ? o_data : sample_data);
        end else check("sample", sel ? o_data : sample_data, exp_q.pop_front());
        check("cs_rise_with_ready", {cs_p, cs}, 2'b01);
        check("sclk_pulses", pulses, FRAME_BITS);
        if (!sel && last_rise >= 0) check("ready_interval", cyc - last_rise, SAMPLE_PERIOD);
        last_rise = cyc;
        if (t_start >= 0) check("latency", cyc - t_start, LATENCY);
        t_start = -1;
        ready_w = 0;
      end
      if (r) ready_w++;
      if (!r && r_p && reset_b) check("ready_width", ready_w, READY_CYCLES);
      r_p = r;
      cs_p = cs;
      sk_p = sk;
    end
  end

  initial begin
    int falls;
    repeat (3) @(negedge clk);
    check("rst_sclk", adc_sclk, 0);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_data", sample_data, 0);
    check("rst_ready", data_ready, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ovr_overrun", o_overrun, 0);
    stim_q = '{10'h2A5, 10'h000, 10'h3FF, 10'h155, 10'h2AA};
    enable = 1;
    reset_b = 1;
    t_start = cyc;
    wait_samples("directed", 5, 6 * SAMPLE_PERIOD);
    wait_samples("random", N_RANDOM, (N_RANDOM + 2) * SAMPLE_PERIOD);
    wait_frame_start("en_frame");
    wait_cycles(50);
    enable = 0;
    falls = cs_falls;
    wait_samples("en_drop_completes", 1, 2 * SAMPLE_PERIOD);
    wait_cycles(3 * SAMPLE_PERIOD);
    check("no_start_while_disabled", cs_falls, falls);
    stim_q.push_back(10'h155);
    enable = 1;
    t_start = cyc;
    last_rise = -1;
    @(negedge clk);
    check("resume_tick_cs", adc_cs_n, 0);
    wait_samples("resume", 1, 2 * SAMPLE_PERIOD);
    wait_frame_start("rst_frame");
    wait_cycles(80);
    reset_b = 0;
    #1;
    check("midrst_cs_n", adc_cs_n, 1);
    check("midrst_sclk", adc_sclk, 0);
    check("midrst_data", sample_data, 0);
    check("midrst_ready", data_ready, 0);
    exp_q.delete();
    wait_cycles(5);
    reset_b = 1;
    t_start = cyc;
    last_rise = -1;
    wait_samples("post_reset", 3, 4 * SAMPLE_PERIOD);
    enable = 0;
    wait_cycles(30);
    sel = 1;
    @(negedge clk);
    o_enable = 1;
    t_start = cyc;
    last_rise = -1;
    wait_cycles(50);
    check("ovr_before_second_tick", o_overrun, 0);
    wait_cycles(70);
    check("ovr_after_second_tick", o_overrun, 1);
    wait_samples("ovr_frames", 3, 4 * 2 * OVR_PERIOD);
    check("ovr_sticky", o_overrun, 1);
    check("main_no_overrun", overrun, 0);
    o_enable = 0;
    wait_cycles(30);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
